// File: rtl/pipe_flow_reg_pkg.sv
// ============================================================================
// Module      : pipe_flow_reg_pkg
// Description : Stage flow codes, default flush NOP and flow-code decoding
//               shared by pipe_flow_reg and its counters.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package pipe_flow_reg_pkg;

    localparam int FLOW_WIDTH = 2;

    localparam logic [FLOW_WIDTH-1:0] FLOW_WORK    = 2'b00;
    localparam logic [FLOW_WIDTH-1:0] FLOW_STOP    = 2'b01;
    localparam logic [FLOW_WIDTH-1:0] FLOW_REFRESH = 2'b10;

    // addi x0, x0, 0
    localparam logic [31:0] PIPE_NOP_INST = 32'h0000_0013;

    typedef enum logic [1:0] {
        MODE_WORK  = 2'd0,
        MODE_STOP  = 2'd1,
        MODE_FLUSH = 2'd2
    } flow_mode_e;

    // Unknown codes fall back to a flush so a corrupted code never leaks data.
    function automatic flow_mode_e decode_flow(input logic [FLOW_WIDTH-1:0] code);
        flow_mode_e mode;
        case (code)
            FLOW_WORK: mode = MODE_WORK;
            FLOW_STOP: mode = MODE_STOP;
            default:   mode = MODE_FLUSH;
        endcase
        return mode;
    endfunction

endpackage : pipe_flow_reg_pkg

`default_nettype wire

// File: rtl/pipe_sat_cnt.sv
// ============================================================================
// Module      : pipe_sat_cnt
// Description : Saturating up-counter with synchronous increment enable and
//               asynchronous active-low clear.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module pipe_sat_cnt #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc_i,
    output logic [CNT_W-1:0] cnt_o
);

    localparam logic [CNT_W-1:0] C_CNT_MAX = '1;

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (inc_i && (cnt_q != C_CNT_MAX)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;

endmodule : pipe_sat_cnt

`default_nettype wire

// File: rtl/pipe_flow_reg.sv
// ============================================================================
// Module      : pipe_flow_reg
// Description : Pipeline boundary register: DEPTH-entry skid buffer for
//               PC/instruction pairs with valid/ready handshakes, stage flow
//               control (WORK/STOP/REFRESH) and stall/flush counters.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module pipe_flow_reg
    import pipe_flow_reg_pkg::*;
#(
    parameter int          PC_W     = 32,
    parameter int          DATA_W   = 32,
    parameter int          DEPTH    = 2,
    parameter logic [31:0] NOP_INST = PIPE_NOP_INST,
    parameter int          CNT_W    = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [FLOW_WIDTH-1:0] flow_i,

    input  logic                  up_valid_i,
    output logic                  up_ready_o,
    input  logic [PC_W-1:0]       up_pc_i,
    input  logic [DATA_W-1:0]     up_inst_i,

    output logic                  dn_valid_o,
    input  logic                  dn_ready_i,
    output logic [PC_W-1:0]       dn_pc_o,
    output logic [DATA_W-1:0]     dn_inst_o,

    output logic [CNT_W-1:0]      stall_cnt_o,
    output logic [CNT_W-1:0]      flush_cnt_o
);

    localparam int PTR_W   = $clog2(DEPTH);
    localparam int COUNT_W = $clog2(DEPTH + 1);

    localparam logic [COUNT_W-1:0] C_FULL = COUNT_W'(DEPTH);
    localparam logic [DATA_W-1:0]  C_NOP  = DATA_W'(NOP_INST);

    logic [PTR_W-1:0]   rd_ptr_q;
    logic [PTR_W-1:0]   rd_ptr_d;
    logic [PTR_W-1:0]   wr_ptr_q;
    logic [PTR_W-1:0]   wr_ptr_d;
    logic [COUNT_W-1:0] count_q;
    logic [COUNT_W-1:0] count_d;

    flow_mode_e         w_mode;
    logic               w_push;
    logic               w_pop;
    logic               w_stall_inc;
    logic               w_flush_inc;

    logic [PC_W-1:0]    w_entry_pc   [DEPTH];
    logic [DATA_W-1:0]  w_entry_inst [DEPTH];

    // ------------------------------------------------------------------------
    // Handshake decode
    // ------------------------------------------------------------------------
    assign w_mode      = decode_flow(flow_i);
    assign up_ready_o  = (w_mode == MODE_WORK) && (count_q != C_FULL);
    assign dn_valid_o  = (count_q != '0);
    assign w_push      = up_valid_i && up_ready_o;
    assign w_pop       = dn_valid_o && dn_ready_i && (w_mode == MODE_WORK);
    assign w_stall_inc = (w_mode == MODE_STOP);
    assign w_flush_inc = (w_mode == MODE_FLUSH) && (count_q != '0);

    // ------------------------------------------------------------------------
    // Pointer and occupancy update
    // ------------------------------------------------------------------------
    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        case (w_mode)
            MODE_WORK: begin
                if (w_push) begin
                    wr_ptr_d = wr_ptr_q + PTR_W'(1);
                end
                if (w_pop) begin
                    rd_ptr_d = rd_ptr_q + PTR_W'(1);
                end
                case ({w_push, w_pop})
                    2'b10:   count_d = count_q + COUNT_W'(1);
                    2'b01:   count_d = count_q - COUNT_W'(1);
                    default: count_d = count_q;
                endcase
            end
            MODE_STOP: begin
                count_d = count_q;
            end
            default: begin
                rd_ptr_d = '0;
                wr_ptr_d = '0;
                count_d  = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    // ------------------------------------------------------------------------
    // Entry storage: each slot only captures when the write pointer targets it
    // ------------------------------------------------------------------------
    for (genvar i = 0; i < DEPTH; i++) begin : g_entry
        logic [PC_W-1:0]   pc_q;
        logic [PC_W-1:0]   pc_d;
        logic [DATA_W-1:0] inst_q;
        logic [DATA_W-1:0] inst_d;

        always_comb begin
            pc_d   = pc_q;
            inst_d = inst_q;
            if (w_push && (wr_ptr_q == PTR_W'(i))) begin
                pc_d   = up_pc_i;
                inst_d = up_inst_i;
            end
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                pc_q   <= '0;
                inst_q <= C_NOP;
            end else begin
                pc_q   <= pc_d;
                inst_q <= inst_d;
            end
        end

        assign w_entry_pc[i]   = pc_q;
        assign w_entry_inst[i] = inst_q;
    end

    // Empty buffer presents a clean bubble rather than stale slot contents.
    assign dn_pc_o   = dn_valid_o ? w_entry_pc[rd_ptr_q]   : '0;
    assign dn_inst_o = dn_valid_o ? w_entry_inst[rd_ptr_q] : C_NOP;

    // ------------------------------------------------------------------------
    // Performance counters
    // ------------------------------------------------------------------------
    pipe_sat_cnt #(
        .CNT_W (CNT_W)
    ) u_stall_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc_i (w_stall_inc),
        .cnt_o (stall_cnt_o)
    );

    pipe_sat_cnt #(
        .CNT_W (CNT_W)
    ) u_flush_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc_i (w_flush_inc),
        .cnt_o (flush_cnt_o)
    );

endmodule : pipe_flow_reg

`default_nettype wire

// File: doc/pipe_flow_reg.md
# pipe_flow_reg

Parametrised pipeline boundary register with flow control, the general successor to the fixed IF/DE latch used between core stages. It carries a PC/instruction pair through a DEPTH-entry skid buffer with a valid/ready handshake on both sides and honours the core's stage flow codes: WORK, STOP and REFRESH. On flush it emits a configurable NOP. Saturating stall and flush counters feed performance monitoring. It is instantiated at any stage boundary in the core (IF/DE, DE/EX, and so on).

## Interface
Parameters:
- PC_W, 32, width of the PC field
- DATA_W, 32, width of the instruction/payload field
- DEPTH, 2, buffer entries; a power of two, at least 2
- NOP_INST, 32'h0000_0013, payload value driven when no entry is valid
- CNT_W, 16, width of each performance counter

Ports:
- clk  in  1  core clock; all state updates on the rising edge
- rst_n  in  1  asynchronous, active-low reset
- flow_i  in  `FLOW_WIDTH  stage flow code: `FLOW_WORK / `FLOW_STOP / `FLOW_REFRESH; any other code is treated as REFRESH
- up_valid_i  in  1  upstream has a PC/instruction pair
- up_ready_o  out  1  the block accepts the pair this cycle
- up_pc_i  in  PC_W  upstream PC
- up_inst_i  in  DATA_W  upstream instruction
- dn_valid_o  out  1  head entry is valid
- dn_ready_i  in  1  downstream consumes the head this cycle
- dn_pc_o  out  PC_W  head PC; 0 when the buffer is empty
- dn_inst_o  out  DATA_W  head instruction; NOP_INST when the buffer is empty
- stall_cnt_o  out  CNT_W  cycles spent in STOP, saturating
- flush_cnt_o  out  CNT_W  REFRESH cycles that discarded at least one valid entry, saturating

## Operation
- Storage: circular buffer with rd_ptr, wr_ptr (log2(DEPTH) bits, wrapping modulo DEPTH) and count (log2(DEPTH+1) bits).
- up_ready_o = (flow_i == WORK) && (count != DEPTH). It is combinational and independent of up_valid_i.
- push = up_valid_i && up_ready_o. pop = dn_valid_o && dn_ready_i && (flow_i == WORK).
- dn_valid_o = (count != 0). Outputs come straight from the head register, with no combinational path from up_* to dn_*.
- WORK:
  - push and pop are independent, and both may occur in the same cycle (count is unchanged).
  - When full, up_ready_o = 0, even if dn_ready_i = 1. There is no same-cycle pass-through.
- STOP:
  - No push and no pop.
  - dn_* is held bit-stable and up_ready_o = 0.
  - stall_cnt increments by 1.
- REFRESH (including illegal codes):
  - On the next edge, count, rd_ptr and wr_ptr are cleared to 0.
  - Incoming data is ignored (up_ready_o = 0).
  - flush_cnt increments if count != 0.
- Counters saturate at all-ones and never wrap.
- Reset values:
  - up_ready_o follows its equation.
  - dn_valid_o = 0, dn_pc_o = 0, dn_inst_o = NOP_INST.
  - stall_cnt_o = 0, flush_cnt_o = 0.
  - Pointers and count are 0.
- Reset asserted mid-operation discards all entries immediately, independent of clk.

## Timing
- Latency: a pair pushed at edge N is visible on dn_* with dn_valid_o = 1 after edge N, i.e. one cycle.
- Throughput: one pair per cycle in WORK when downstream is always ready.
- REFRESH at cycle N: after edge N, dn_valid_o = 0 and dn_inst_o = NOP_INST. In cycle N+1, up_ready_o = 1 again if flow_i has returned to WORK.
- STOP → WORK: the held head is consumed on the first WORK cycle in which dn_ready_i = 1. Nothing is lost or duplicated.
- Counter outputs are registered and update one edge after the qualifying cycle.

## Structure
- FLOW_WIDTH, FLOW_WORK, FLOW_STOP and FLOW_REFRESH remain in the shared rooth_defines.v.
- Add PIPE_NOP_INST to rooth_defines.v as the default for NOP_INST.
- One natural sub-module: pipe_sat_cnt (CNT_W, synchronous increment enable, asynchronous active-low clear), instantiated twice.
- Buffer storage and pointers stay inline in pipe_flow_reg.

## Test plan
- Reset, then WORK; push PC = 0x100, inst = 0x00A00093 at edge 1, dn_ready_i = 1 → dn_valid_o = 1, dn_pc_o = 0x100 after edge 1; dn_valid_o = 0 after edge 2.
- DEPTH = 2, WORK, dn_ready_i = 0, three pushes offered (PC 0x0, 0x4, 0x8) → up_ready_o drops after the second push; dn_ready_i = 1 then drains 0x0, 0x4 in order; 0x8 is accepted only once space frees.
- Full buffer, flow_i = STOP for 5 cycles with dn_ready_i = 1 → dn_* unchanged, no pops, stall_cnt_o = 5; on return to WORK, head 0x0 is popped first.
- Two valid entries, one REFRESH cycle → dn_valid_o = 0, dn_inst_o = NOP_INST, flush_cnt_o = 1; a second REFRESH with the buffer empty leaves flush_cnt_o = 1.
- CNT_W = 4, STOP held for 20 cycles → stall_cnt_o sticks at 15; illegal flow code 2'b11 behaves exactly as REFRESH.
- rst_n pulsed low between clock edges with 2 entries valid → dn_valid_o = 0 immediately, counters 0; WORK traffic resumes cleanly after release.
